lmc_core_p: RTL and testbench

//  Parametrised Little-Man-Computer style CPU core; next generation of the R52 accumulator machine.

---
 rtl/lmc_core_p.sv | 236 +++++++++++++++++++++++
 tb/tb_lmc_core_p.sv | 438 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lmc_core_p.sv
// lmc_core_p: Little-Man-Computer style accumulator CPU.
// Unified program/data RAM with synchronous read, accumulator with Z/PZ/V flags,
// and INP/OUT ports using valid/ready handshakes. Programs are loaded through the
// write port while halted. A run pulse starts execution at address 0.
// DATA_WIDTH must be at least ADDR_WIDTH+4 so that opcode and operand fit in one word.
module lmc_core_p #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 12
) (
    input  logic                  timer555,
    input  logic                  reset_count,
    input  logic                  run,
    input  logic                  prog_we,
    input  logic [ADDR_WIDTH-1:0] prog_addr,
    input  logic [DATA_WIDTH-1:0] prog_data,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] Acc_out,
    output logic [ADDR_WIDTH-1:0] pc_out,
    output logic                  Z_flag,
    output logic                  PZ_flag,
    output logic                  V_flag,
    output logic                  halted,
    output logic                  err
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int MSB   = DATA_WIDTH - 1;

    localparam logic [3:0] OP_HLT = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_STA = 4'h3;
    localparam logic [3:0] OP_LDA = 4'h5;
    localparam logic [3:0] OP_BRA = 4'h6;
    localparam logic [3:0] OP_BRZ = 4'h7;
    localparam logic [3:0] OP_BRP = 4'h8;
    localparam logic [3:0] OP_INP = 4'h9;
    localparam logic [3:0] OP_OUT = 4'hA;

    typedef enum logic [2:0] {
        S_HALT,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WAIT_IN,
        S_WAIT_OUT
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [3:0]            ir_op_q, ir_op_d;
    logic [ADDR_WIDTH-1:0] ir_opnd_q, ir_opnd_d;
    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  out_valid_q, out_valid_d;
    logic                  v_q, v_d;
    logic                  err_q, err_d;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] ram_q;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_wdata;
    logic                  ram_we;

    logic [DATA_WIDTH-1:0] sum;
    logic [DATA_WIDTH-1:0] diff;
    logic                  add_ovf;
    logic                  sub_ovf;
    logic                  acc_zero;
    logic                  acc_pos;

    // RAM: single port, registered read every cycle, write suppressed during reset; contents survive reset
    always_ff @(posedge timer555) begin
        if (ram_we && !reset_count) begin
            mem[ram_addr] <= ram_wdata;
        end
        ram_q <= mem[ram_addr];
    end

    // Adder/subtractor on Acc and the RAM read word, with two's-complement overflow detection
    always_comb begin
        sum      = acc_q + ram_q;
        diff     = acc_q - ram_q;
        add_ovf  = (acc_q[MSB] == ram_q[MSB]) && (sum[MSB] != acc_q[MSB]);
        sub_ovf  = (acc_q[MSB] != ram_q[MSB]) && (diff[MSB] != acc_q[MSB]);
        acc_zero = (acc_q == '0);
        acc_pos  = !acc_q[MSB];
    end

    // Sequencer: next state, register updates and RAM port control, defaults first
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_op_d     = ir_op_q;
        ir_opnd_d   = ir_opnd_q;
        acc_d       = acc_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        v_d         = v_q;
        err_d       = err_q;
        ram_addr    = pc_q;
        ram_wdata   = acc_q;
        ram_we      = 1'b0;

        case (state_q)
            S_HALT: begin
                ram_addr  = prog_addr;
                ram_wdata = prog_data;
                ram_we    = prog_we;
                if (run) begin
                    pc_d    = '0;
                    err_d   = 1'b0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                ram_addr = pc_q;
                state_d  = S_DECODE;
            end
            S_DECODE: begin
                ir_op_d   = ram_q[DATA_WIDTH-1 -: 4];
                ir_opnd_d = ram_q[ADDR_WIDTH-1:0];
                pc_d      = pc_q + ADDR_WIDTH'(1);
                state_d   = S_EXEC;
            end
            S_EXEC: begin
                ram_addr = ir_opnd_q;
                state_d  = S_FETCH;
                case (ir_op_q)
                    OP_HLT: state_d = S_HALT;
                    OP_ADD, OP_SUB, OP_LDA: state_d = S_MEM;
                    OP_STA: ram_we = 1'b1;
                    OP_BRA: pc_d = ir_opnd_q;
                    OP_BRZ: begin
                        if (acc_zero) begin
                            pc_d = ir_opnd_q;
                        end
                    end
                    OP_BRP: begin
                        if (acc_pos) begin
                            pc_d = ir_opnd_q;
                        end
                    end
                    OP_INP: state_d = S_WAIT_IN;
                    OP_OUT: begin
                        out_data_d  = acc_q;
                        out_valid_d = 1'b1;
                        state_d     = S_WAIT_OUT;
                    end
                    default: begin
                        err_d   = 1'b1;
                        state_d = S_HALT;
                    end
                endcase
            end
            S_MEM: begin
                state_d = S_FETCH;
                case (ir_op_q)
                    OP_LDA: begin
                        acc_d = ram_q;
                        v_d   = 1'b0;
                    end
                    OP_ADD: begin
                        acc_d = sum;
                        v_d   = add_ovf;
                    end
                    OP_SUB: begin
                        acc_d = diff;
                        v_d   = sub_ovf;
                    end
                    default: begin
                        acc_d = acc_q;
                    end
                endcase
            end
            S_WAIT_IN: begin
                if (in_valid) begin
                    acc_d   = in_data;
                    state_d = S_FETCH;
                end
            end
            S_WAIT_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_FETCH;
                end
            end
            default: begin
                state_d = S_HALT;
            end
        endcase
    end

    // State and datapath registers with synchronous reset back to the halted idle state
    always_ff @(posedge timer555) begin
        if (reset_count) begin
            state_q     <= S_HALT;
            pc_q        <= '0;
            ir_op_q     <= '0;
            ir_opnd_q   <= '0;
            acc_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            v_q         <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_op_q     <= ir_op_d;
            ir_opnd_q   <= ir_opnd_d;
            acc_q       <= acc_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            v_q         <= v_d;
            err_q       <= err_d;
        end
    end

    assign in_ready  = (state_q == S_WAIT_IN);
    assign halted    = (state_q == S_HALT);
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign Acc_out   = acc_q;
    assign pc_out    = pc_q;
    assign Z_flag    = acc_zero;
    assign PZ_flag   = acc_pos;
    assign V_flag    = v_q;
    assign err       = err_q;

endmodule

// File: tb/tb_lmc_core_p.sv
// tb_lmc_core_p: directed scenarios plus random programs checked against an
// instruction-level interpreter of the LMC instruction set.
module tb_lmc_core_p;

    localparam int AW    = 4;
    localparam int DW    = 12;
    localparam int DEPTH = 16;

    logic          timer555;
    logic          reset_count;
    logic          run;
    logic          prog_we;
    logic [AW-1:0] prog_addr;
    logic [DW-1:0] prog_data;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] Acc_out;
    logic [AW-1:0] pc_out;
    logic          Z_flag;
    logic          PZ_flag;
    logic          V_flag;
    logic          halted;
    logic          err;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] obs_out[$];
    logic [DW-1:0] in_list[$];
    int            in_pos;
    bit            auto_in;
    bit            watch_seen;
    logic [DW-1:0] watch_val;
    logic          watch_pz;
    logic          watch_z;

    logic [DW-1:0] prog [DEPTH];
    logic [3:0]    legal_ops [9] = '{4'h1, 4'h2, 4'h3, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA};

    logic [DW-1:0] m_mem [DEPTH];
    logic [DW-1:0] m_acc;
    logic [AW-1:0] m_pc;
    logic          m_v;
    logic          m_err;
    bit            m_done;
    bit            m_io;
    int            m_cycles;
    logic [DW-1:0] m_outs[$];

    lmc_core_p #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW)
    ) dut (
        .timer555   (timer555),
        .reset_count(reset_count),
        .run        (run),
        .prog_we    (prog_we),
        .prog_addr  (prog_addr),
        .prog_data  (prog_data),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .Acc_out    (Acc_out),
        .pc_out     (pc_out),
        .Z_flag     (Z_flag),
        .PZ_flag    (PZ_flag),
        .V_flag     (V_flag),
        .halted     (halted),
        .err        (err)
    );

    initial timer555 = 1'b0;
    always #5 timer555 = ~timer555;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // One clock: sample handshakes on the falling edge, update the input source just after the rising edge
    task automatic tick();
        bit hs_in;
        @(negedge timer555);
        hs_in = in_valid && in_ready;
        if (out_valid && out_ready) obs_out.push_back(out_data);
        @(posedge timer555);
        #1;
        if (hs_in) in_pos++;
        in_valid = auto_in && (in_pos < in_list.size());
        in_data  = in_valid ? in_list[in_pos] : '0;
        if (!watch_seen && (Acc_out === watch_val)) begin
            watch_seen = 1'b1;
            watch_pz   = PZ_flag;
            watch_z    = Z_flag;
        end
    endtask

    task automatic applyStimulus(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data, input logic go);
        prog_we   = we;
        prog_addr = addr;
        prog_data = data;
        run       = go;
        tick();
        prog_we   = 1'b0;
        run       = 1'b0;
    endtask

    task automatic load_program();
        for (int a = 0; a < DEPTH; a++) applyStimulus(1'b1, AW'(a), prog[a], 1'b0);
    endtask

    task automatic do_reset();
        reset_count = 1'b1;
        tick();
        reset_count = 1'b0;
    endtask

    task automatic wait_halt(input int budget, input string tag, output int n);
        n = 0;
        while (!halted && n < budget) begin
            tick();
            n++;
        end
        checkOutput({tag, "_halted"}, 32'(halted), 32'd1);
    endtask

    function automatic logic [31:0] out_at(input int i);
        if (i < obs_out.size()) return 32'(obs_out[i]);
        return 32'hFFFF_FFFF;
    endfunction

    function automatic void gen_program();
        logic [3:0] op;
        int         r;
        for (int a = 0; a < DEPTH; a++) begin
            r = int'($urandom_range(0, 99));
            if (r < 6) op = 4'h0;
            else if (r < 9) op = 4'h4;
            else if (r < 11) op = 4'(int'($urandom_range(11, 15)));
            else op = legal_ops[int'($urandom_range(0, 8))];
            prog[a] = {op, 4'($urandom), 4'($urandom)};
        end
    endfunction

    // Instruction-level interpreter: executes whole instructions from the ISA rules
    function automatic void model_run();
        logic [DW-1:0] w;
        logic [3:0]    op;
        logic [AW-1:0] a;
        int            sa;
        int            sb;
        int            r;
        int            in_i;
        m_pc     = '0;
        m_err    = 1'b0;
        m_done   = 0;
        m_io     = 0;
        m_cycles = 0;
        in_i     = 0;
        m_outs.delete();
        for (int s = 0; s < 60; s++) begin
            if (m_done) break;
            w    = m_mem[m_pc];
            op   = w[DW-1 -: 4];
            a    = w[AW-1:0];
            m_pc = AW'(int'(m_pc) + 1);
            case (op)
                4'h0: begin
                    m_done = 1;
                    m_cycles += 3;
                end
                4'h1, 4'h2: begin
                    sa = int'($signed(m_acc));
                    sb = int'($signed(m_mem[a]));
                    r  = (op == 4'h1) ? sa + sb : sa - sb;
                    m_v   = (r > (1 << (DW - 1)) - 1) || (r < -(1 << (DW - 1)));
                    m_acc = DW'(r);
                    m_cycles += 4;
                end
                4'h3: begin
                    m_mem[a] = m_acc;
                    m_cycles += 3;
                end
                4'h5: begin
                    m_acc = m_mem[a];
                    m_v   = 1'b0;
                    m_cycles += 4;
                end
                4'h6: begin
                    m_pc = a;
                    m_cycles += 3;
                end
                4'h7: begin
                    if (m_acc == '0) m_pc = a;
                    m_cycles += 3;
                end
                4'h8: begin
                    if (int'($signed(m_acc)) >= 0) m_pc = a;
                    m_cycles += 3;
                end
                4'h9: begin
                    m_acc = in_list[in_i];
                    in_i++;
                    m_io = 1;
                end
                4'hA: begin
                    m_outs.push_back(m_acc);
                    m_io = 1;
                end
                default: begin
                    m_err  = 1'b1;
                    m_done = 1;
                    m_cycles += 3;
                end
            endcase
        end
    endfunction

    initial begin
        int n;
        int tries;

        reset_count = 1'b1;
        run         = 1'b0;
        prog_we     = 1'b0;
        prog_addr   = '0;
        prog_data   = '0;
        in_data     = '0;
        in_valid    = 1'b0;
        out_ready   = 1'b1;
        auto_in     = 1'b0;
        in_pos      = 0;
        watch_seen  = 1'b1;
        watch_val   = '0;
        watch_pz    = 1'b0;
        watch_z     = 1'b0;

        // Reset state
        tick();
        tick();
        reset_count = 1'b0;
        tick();
        checkOutput("rst_halted", 32'(halted), 32'd1);
        checkOutput("rst_pc", 32'(pc_out), 32'd0);
        checkOutput("rst_acc", 32'(Acc_out), 32'd0);
        checkOutput("rst_z", 32'(Z_flag), 32'd1);
        checkOutput("rst_pz", 32'(PZ_flag), 32'd1);
        checkOutput("rst_v", 32'(V_flag), 32'd0);
        checkOutput("rst_err", 32'(err), 32'd0);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_data", 32'(out_data), 32'd0);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd0);

        // Max-of-two program, inputs 3 then 5
        for (int a = 0; a < DEPTH; a++) prog[a] = '0;
        prog[0] = 12'h900; prog[1] = 12'h30E; prog[2]  = 12'h900; prog[3] = 12'h30F;
        prog[4] = 12'h20E; prog[5] = 12'h808; prog[6]  = 12'h50E; prog[7] = 12'h609;
        prog[8] = 12'h50F; prog[9] = 12'hA00; prog[10] = 12'h000;
        load_program();
        in_list = '{12'd3, 12'd5};
        in_pos  = 0;
        auto_in = 1'b1;
        obs_out.delete();
        applyStimulus(1'b0, '0, '0, 1'b1);
        wait_halt(200, "t1", n);
        checkOutput("t1_out_count", 32'(obs_out.size()), 32'd1);
        checkOutput("t1_out", out_at(0), 32'd5);
        checkOutput("t1_pc", 32'(pc_out), 32'd11);
        checkOutput("t1_err", 32'(err), 32'd0);

        // Same program, inputs 7 then 2: SUB goes negative so BRP falls through
        in_list    = '{12'd7, 12'd2};
        in_pos     = 0;
        watch_val  = 12'hFFB;
        watch_seen = 1'b0;
        obs_out.delete();
        applyStimulus(1'b0, '0, '0, 1'b1);
        wait_halt(200, "t2", n);
        checkOutput("t2_out", out_at(0), 32'd7);
        checkOutput("t2_pc", 32'(pc_out), 32'd11);
        checkOutput("t2_saw_fffb", 32'(watch_seen), 32'd1);
        checkOutput("t2_pz_at_fffb", 32'(watch_pz), 32'd0);
        checkOutput("t2_z_at_fffb", 32'(watch_z), 32'd0);
        watch_seen = 1'b1;

        // Signed overflow on ADD, then SUB back to zero with Acc carried across runs
        applyStimulus(1'b1, 4'h0, 12'h508, 1'b0);
        applyStimulus(1'b1, 4'h1, 12'h109, 1'b0);
        applyStimulus(1'b1, 4'h2, 12'h000, 1'b0);
        applyStimulus(1'b1, 4'h8, 12'h7FF, 1'b0);
        applyStimulus(1'b1, 4'h9, 12'h001, 1'b0);
        applyStimulus(1'b1, 4'hA, 12'h800, 1'b0);
        applyStimulus(1'b0, '0, '0, 1'b1);
        wait_halt(100, "t3a", n);
        checkOutput("t3a_acc", 32'(Acc_out), 32'h800);
        checkOutput("t3a_v", 32'(V_flag), 32'd1);
        checkOutput("t3a_pz", 32'(PZ_flag), 32'd0);
        checkOutput("t3a_z", 32'(Z_flag), 32'd0);
        checkOutput("t3a_pc", 32'(pc_out), 32'd3);
        checkOutput("t3a_cycles", 32'(n), 32'd11);
        applyStimulus(1'b1, 4'h1, 12'h000, 1'b0);
        applyStimulus(1'b1, 4'h0, 12'h20A, 1'b1);
        wait_halt(100, "t3b", n);
        checkOutput("t3b_acc", 32'(Acc_out), 32'h000);
        checkOutput("t3b_z", 32'(Z_flag), 32'd1);
        checkOutput("t3b_v", 32'(V_flag), 32'd0);
        checkOutput("t3b_pz", 32'(PZ_flag), 32'd1);
        checkOutput("t3b_pc", 32'(pc_out), 32'd2);

        // OUT back-pressure: value held and PC frozen while out_ready is low
        applyStimulus(1'b1, 4'h0, 12'h504, 1'b0);
        applyStimulus(1'b1, 4'h1, 12'hA00, 1'b0);
        applyStimulus(1'b1, 4'h2, 12'h000, 1'b0);
        applyStimulus(1'b1, 4'h4, 12'h5A3, 1'b0);
        out_ready = 1'b0;
        obs_out.delete();
        applyStimulus(1'b0, '0, '0, 1'b1);
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        checkOutput("t4_valid_rise", 32'(out_valid), 32'd1);
        for (int k = 0; k < 5; k++) begin
            tick();
            checkOutput($sformatf("t4_hold%0d_valid", k), 32'(out_valid), 32'd1);
            checkOutput($sformatf("t4_hold%0d_data", k), 32'(out_data), 32'h5A3);
            checkOutput($sformatf("t4_hold%0d_pc", k), 32'(pc_out), 32'd2);
        end
        out_ready = 1'b1;
        wait_halt(50, "t4", n);
        checkOutput("t4_transfers", 32'(obs_out.size()), 32'd1);
        checkOutput("t4_out", out_at(0), 32'h5A3);
        checkOutput("t4_valid_low", 32'(out_valid), 32'd0);

        // Illegal opcode halts with err; a RAM write while running is ignored
        applyStimulus(1'b1, 4'h0, 12'h508, 1'b0);
        applyStimulus(1'b1, 4'h1, 12'h309, 1'b0);
        applyStimulus(1'b1, 4'h2, 12'h400, 1'b0);
        applyStimulus(1'b1, 4'h8, 12'h123, 1'b0);
        applyStimulus(1'b0, '0, '0, 1'b1);
        applyStimulus(1'b1, 4'h8, 12'hABC, 1'b0);
        wait_halt(100, "t5a", n);
        checkOutput("t5a_err", 32'(err), 32'd1);
        checkOutput("t5a_pc", 32'(pc_out), 32'd3);
        checkOutput("t5a_acc", 32'(Acc_out), 32'h123);
        applyStimulus(1'b1, 4'h0, 12'h508, 1'b0);
        applyStimulus(1'b1, 4'h1, 12'h000, 1'b0);
        applyStimulus(1'b0, '0, '0, 1'b1);
        checkOutput("t5b_err_cleared", 32'(err), 32'd0);
        wait_halt(100, "t5b", n);
        checkOutput("t5b_acc", 32'(Acc_out), 32'h123);
        checkOutput("t5b_pc", 32'(pc_out), 32'd2);

        // Reset while waiting in INP, then rerun to confirm RAM survived
        applyStimulus(1'b1, 4'h0, 12'h508, 1'b0);
        applyStimulus(1'b1, 4'h1, 12'h900, 1'b0);
        applyStimulus(1'b1, 4'h2, 12'h000, 1'b0);
        applyStimulus(1'b1, 4'h8, 12'h456, 1'b0);
        auto_in = 1'b0;
        applyStimulus(1'b0, '0, '0, 1'b1);
        n = 0;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        checkOutput("t6_in_ready", 32'(in_ready), 32'd1);
        checkOutput("t6_acc_before", 32'(Acc_out), 32'h456);
        reset_count = 1'b1;
        tick();
        checkOutput("t6_pc", 32'(pc_out), 32'd0);
        checkOutput("t6_acc", 32'(Acc_out), 32'd0);
        checkOutput("t6_in_ready_low", 32'(in_ready), 32'd0);
        checkOutput("t6_halted", 32'(halted), 32'd1);
        reset_count = 1'b0;
        in_list    = '{12'h321};
        in_pos     = 0;
        auto_in    = 1'b1;
        watch_val  = 12'h456;
        watch_seen = 1'b0;
        applyStimulus(1'b0, '0, '0, 1'b1);
        wait_halt(100, "t6r", n);
        checkOutput("t6r_ram_kept", 32'(watch_seen), 32'd1);
        checkOutput("t6r_acc", 32'(Acc_out), 32'h321);
        checkOutput("t6r_pc", 32'(pc_out), 32'd3);
        watch_seen = 1'b1;

        // Random programs against the interpreter
        for (int t = 0; t < 8; t++) begin
            tries = 0;
            do begin
                gen_program();
                for (int a = 0; a < DEPTH; a++) m_mem[a] = prog[a];
                in_list.delete();
                for (int k = 0; k < 64; k++) in_list.push_back(DW'($urandom));
                m_acc = '0;
                m_v   = 1'b0;
                model_run();
                tries++;
            end while (!m_done && tries < 50);
            if (m_done) begin
                in_pos    = 0;
                auto_in   = 1'b1;
                out_ready = 1'b1;
                do_reset();
                load_program();
                obs_out.delete();
                applyStimulus(1'b0, '0, '0, 1'b1);
                wait_halt(600, $sformatf("r%0d", t), n);
                checkOutput($sformatf("r%0d_acc", t), 32'(Acc_out), 32'(m_acc));
                checkOutput($sformatf("r%0d_pc", t), 32'(pc_out), 32'(m_pc));
                checkOutput($sformatf("r%0d_err", t), 32'(err), 32'(m_err));
                checkOutput($sformatf("r%0d_v", t), 32'(V_flag), 32'(m_v));
                checkOutput($sformatf("r%0d_z", t), 32'(Z_flag), 32'(m_acc == '0));
                checkOutput($sformatf("r%0d_pz", t), 32'(PZ_flag), 32'(int'($signed(m_acc)) >= 0));
                checkOutput($sformatf("r%0d_out_count", t), 32'(obs_out.size()), 32'(m_outs.size()));
                for (int k = 0; k < m_outs.size(); k++)
                    checkOutput($sformatf("r%0d_out%0d", t, k), out_at(k), 32'(m_outs[k]));
                if (!m_io) checkOutput($sformatf("r%0d_cycles", t), 32'(n), 32'(m_cycles));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
